// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary assembler.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIGIT_W        = 4;
   localparam int MAX_DIGIT      = 9;
   localparam int DEF_NUM_DIGITS = 3;
   localparam int DEF_OUT_W      = 8;

endpackage

// File: rtl/bcd_assembler_if.sv
// Word-in / result-out handshake bundle for bcd_assembler.
interface bcd_assembler_if #(
   parameter int NUM_DIGITS = bcd_pkg::DEF_NUM_DIGITS,
   parameter int OUT_W      = bcd_pkg::DEF_OUT_W
);

   logic                               in_valid;
   logic                               in_ready;
   logic [bcd_pkg::DIGIT_W*NUM_DIGITS-1:0] bcd_in;
   logic                               out_valid;
   logic                               out_ready;
   logic [OUT_W-1:0]                   bin_out;
   logic                               ovf;
   logic                               bad_digit;

   // Producer of digit words and consumer of results.
   modport master (
      output in_valid, bcd_in, out_ready,
      input  in_ready, out_valid, bin_out, ovf, bad_digit
   );

   // The converter itself.
   modport slave (
      input  in_valid, bcd_in, out_ready,
      output in_ready, out_valid, bin_out, ovf, bad_digit
   );

endinterface

// File: rtl/bcd_mac10.sv
// One Horner step: acc*10 + digit, clamped to the output width.
module bcd_mac10
   import bcd_pkg::*;
#(
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic [OUT_W-1:0]   acc,
   input  logic [DIGIT_W-1:0] digit,
   output logic [OUT_W-1:0]   acc_next,
   output logic               sat,
   output logic               bad
);

   // Four spare bits hold 10*(2^OUT_W-1)+15 without wrapping.
   localparam int SUM_W = OUT_W + DIGIT_W;

   logic [SUM_W-1:0] acc_ext;
   logic [SUM_W-1:0] sum;

   // Multiply by ten as x8 + x2, add the digit, saturate on any carry into the spare bits.
   always_comb begin
      acc_ext  = {{DIGIT_W{1'b0}}, acc};
      sum      = (acc_ext << 3) + (acc_ext << 1) + {{OUT_W{1'b0}}, digit};
      sat      = |sum[SUM_W-1:OUT_W];
      acc_next = sat ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
      bad      = digit > DIGIT_W'(MAX_DIGIT);
   end

endmodule

// File: rtl/bcd_assembler.sv
// Sequential BCD-to-binary converter, most-significant digit first, one digit per clock.
//
//   state | meaning
//   IDLE  | ready for a new packed BCD word
//   CONV  | folding one digit per cycle into the accumulator
//   DONE  | result held on the output until the consumer takes it
module bcd_assembler
   import bcd_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int OUT_W      = DEF_OUT_W
) (
   input  logic         clk,
   input  logic         reset,
   bcd_assembler_if.slave bus
);

   localparam int SR_W  = DIGIT_W * NUM_DIGITS;
   localparam int CNT_W = $clog2(NUM_DIGITS + 1);

   state_t             state_q,     state_d;
   logic [SR_W-1:0]    sreg_q,      sreg_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [OUT_W-1:0]   acc_q,       acc_d;
   logic               ovf_acc_q,   ovf_acc_d;
   logic               bad_acc_q,   bad_acc_d;
   logic [OUT_W-1:0]   bin_q,       bin_d;
   logic               ovf_q,       ovf_d;
   logic               bad_q,       bad_d;
   logic               in_ready_q,  in_ready_d;
   logic               out_valid_q, out_valid_d;

   logic [OUT_W-1:0]   mac_acc;
   logic               mac_sat;
   logic               mac_bad;
   logic               last_digit;

   bcd_mac10 #(.OUT_W(OUT_W)) u_mac (
      .acc      (acc_q),
      .digit    (sreg_q[SR_W-1 -: DIGIT_W]),
      .acc_next (mac_acc),
      .sat      (mac_sat),
      .bad      (mac_bad)
   );

   assign last_digit = (cnt_q == CNT_W'(NUM_DIGITS - 1));

   // Next-state and datapath decode; handshake outputs are registered from the next state.
   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      ovf_acc_d = ovf_acc_q;
      bad_acc_d = bad_acc_q;
      bin_d     = bin_q;
      ovf_d     = ovf_q;
      bad_d     = bad_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               sreg_d    = bus.bcd_in;
               cnt_d     = '0;
               acc_d     = '0;
               ovf_acc_d = 1'b0;
               bad_acc_d = 1'b0;
               state_d   = CONV;
            end
         end
         CONV: begin
            acc_d     = mac_acc;
            ovf_acc_d = ovf_acc_q | mac_sat;
            bad_acc_d = bad_acc_q | mac_bad;
            sreg_d    = sreg_q << DIGIT_W;
            cnt_d     = cnt_q + CNT_W'(1);
            if (last_digit) begin
               // A bad nibble makes the magnitude meaningless, so report zero.
               bin_d   = (bad_acc_q | mac_bad) ? '0 : mac_acc;
               ovf_d   = ovf_acc_q | mac_sat;
               bad_d   = bad_acc_q | mac_bad;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // Register all state; reset aborts any conversion in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         ovf_acc_q   <= 1'b0;
         bad_acc_q   <= 1'b0;
         bin_q       <= '0;
         ovf_q       <= 1'b0;
         bad_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         ovf_acc_q   <= ovf_acc_d;
         bad_acc_q   <= bad_acc_d;
         bin_q       <= bin_d;
         ovf_q       <= ovf_d;
         bad_q       <= bad_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.bin_out   = bin_q;
   assign bus.ovf       = ovf_q;
   assign bus.bad_digit = bad_q;

endmodule

// File: tb/tb_bcd_assembler.sv
// Scoreboard bench for bcd_assembler: directed corner words plus randomized traffic.
module tb_bcd_assembler;

   localparam int ND   = 3;
   localparam int OW   = 8;
   localparam int MAXV = (1 << OW) - 1;

   logic clk;
   logic reset;
   int   cyc;
   int   n_cmp;
   int   n_bad;
   bit   rnd_bp;
   bit   ov_prev;

   logic [OW+1:0] exp_q[$];
   int            acc_cyc_q[$];

   bcd_assembler_if #(.NUM_DIGITS(ND), .OUT_W(OW)) bus ();

   bcd_assembler #(.NUM_DIGITS(ND), .OUT_W(OW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Random consumer backpressure during the random phase.
   always @(posedge clk) begin
      if (rnd_bp) begin
         #1;
         bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // Reference: decimal value of the three nibbles taken at face value.
   function automatic logic [OW+1:0] model(input logic [4*ND-1:0] w);
      int h, t, o, val, bin;
      bit bad, ovf;
      h   = int'(w[11:8]);
      t   = int'(w[7:4]);
      o   = int'(w[3:0]);
      bad = (h > 9) || (t > 9) || (o > 9);
      val = h * 100 + t * 10 + o;
      ovf = val > MAXV;
      bin = bad ? 0 : (ovf ? MAXV : val);
      return {bad, ovf, OW'(bin)};
   endfunction

   // Monitor: samples at the falling edge; handshakes seen here complete on the next rising edge.
   always @(negedge clk) begin
      logic [OW+1:0] e;
      if (reset) begin
         exp_q.delete();
         acc_cyc_q.delete();
         ov_prev = 1'b0;
      end else begin
         if (bus.out_valid && !ov_prev) begin
            if (exp_q.size() == 0) fail("unexpected_out_valid");
            // accept edge E0, last digit at E0+ND, first seen at the falling edge after that
            else check("latency", cyc - acc_cyc_q[0], ND + 1);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               fail("result_without_word");
            end else begin
               e = exp_q.pop_front();
               void'(acc_cyc_q.pop_front());
               check("bin_out",   int'(bus.bin_out),   int'(e[OW-1:0]));
               check("ovf",       int'(bus.ovf),       int'(e[OW]));
               check("bad_digit", int'(bus.bad_digit), int'(e[OW+1]));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.bcd_in));
            acc_cyc_q.push_back(cyc);
         end
         ov_prev = bus.out_valid;
      end
   end

   // Present a word until accepted; returns #1 after the accepting edge.
   task automatic send(input logic [4*ND-1:0] w, input bit hold, output int acc_cyc);
      bit done;
      done          = 1'b0;
      acc_cyc       = 0;
      bus.in_valid  = 1'b1;
      bus.bcd_in    = w;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            done    = 1'b1;
            acc_cyc = cyc;
         end
         @(posedge clk);
         #1;
      end
      if (!done) fail("send_timeout");
      if (!hold) bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) fail("drain_timeout");
   endtask

   task automatic wait_out_valid();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bus.out_valid;
      end
      if (!seen) fail("out_valid_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, c0, c1, c2;
      logic [4*ND-1:0] dir_words[7];
      logic [4*ND-1:0] w;

      dir_words = '{12'h123, 12'h255, 12'h256, 12'h999, 12'h000, 12'h1A5, 12'h3F9};
      n_cmp = 0;
      n_bad = 0;
      cyc = 0;
      rnd_bp = 1'b0;
      ov_prev = 1'b0;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.bcd_in = '0;
      bus.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  int'(bus.in_ready),  0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_bin_out",   int'(bus.bin_out),   0);
      check("rst_ovf",       int'(bus.ovf),       0);
      check("rst_bad_digit", int'(bus.bad_digit), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post_rst_in_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;

      // Basic conversion and the saturation / invalid-digit corners.
      foreach (dir_words[i]) begin
         send(dir_words[i], 1'b0, c);
         drain();
      end

      // Backpressure: result held, a word presented meanwhile is ignored.
      bus.out_ready = 1'b0;
      send(12'h042, 1'b0, c);
      bus.in_valid = 1'b1;
      bus.bcd_in   = 12'h077;
      wait_out_valid();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", int'(bus.out_valid), 1);
         check("bp_bin_out",   int'(bus.bin_out),   42);
         check("bp_in_ready",  int'(bus.in_ready),  0);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_in_ready_after", int'(bus.in_ready), 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      drain();

      // Reset one cycle into a conversion.
      send(12'h200, 1'b0, c);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("abort_out_valid", int'(bus.out_valid), 0);
      check("abort_in_ready",  int'(bus.in_ready),  0);
      check("abort_bin_out",   int'(bus.bin_out),   0);
      check("abort_ovf",       int'(bus.ovf),       0);
      check("abort_bad_digit", int'(bus.bad_digit), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("abort_no_output", int'(bus.out_valid), 0);
      end
      @(posedge clk);
      #1;
      send(12'h010, 1'b0, c);
      drain();

      // Back-to-back stream with in_valid held high.
      send(12'h001, 1'b1, c0);
      send(12'h128, 1'b1, c1);
      send(12'h250, 1'b0, c2);
      check("b2b_gap1", c1 - c0, ND + 2);
      check("b2b_gap2", c2 - c1, ND + 2);
      drain();

      // Random words, mostly legal digits, under random backpressure.
      rnd_bp = 1'b1;
      for (int k = 0; k < 40; k++) begin
         for (int d = 0; d < ND; d++) begin
            w[d*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(0, 9));
         end
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         send(w, 1'b0, c);
      end
      rnd_bp = 1'b0;
      @(posedge clk);
      #2 bus.out_ready = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_assembler.md
# bcd_assembler

Sequential BCD-to-binary converter: the inverse of the design's binary-to-decimal digit split. It accepts a packed group of BCD digits (hundreds, tens, ones) over a valid/ready handshake. It accumulates them most-significant digit first, computing `acc = acc*10 + digit` at one digit per clock. It returns a saturated binary value with overflow and invalid-digit flags. It sits between keypad or switch digit entry and the binary lookup/ROM address path.

## Interface
- `NUM_DIGITS`, default 3: number of BCD digits per input word.
- `OUT_W`, default 8: width of the binary result.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: `bcd_in` holds a word to convert.
- `in_ready` output 1: block can accept a word this cycle.
- `bcd_in` input 4*NUM_DIGITS: packed digits; bits [3:0] are ones, [7:4] tens, [11:8] hundreds.
- `out_valid` output 1: `bin_out`, `ovf` and `bad_digit` hold a completed result.
- `out_ready` input 1: consumer takes the result this cycle.
- `bin_out` output OUT_W: converted value.
- `ovf` output 1: decimal value exceeded 2^OUT_W-1.
- `bad_digit` output 1: some input nibble was greater than 9.

## Operation
- The FSM has three states: IDLE, CONV and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `bcd_in` into the digit shift register, clear the accumulator, digit counter and sticky flags, then go to CONV.
- **CONV**
  - `in_ready`=0.
  - Each cycle, process the top nibble of the shift register: `acc_next = acc*10 + nibble`, with `acc*10` formed as `(acc<<3)+(acc<<1)`.
  - Shift the register left by 4 and increment the counter.
  - After NUM_DIGITS digits, register the results and go to DONE.
- **Width and saturation**
  - The intermediate sum is computed at OUT_W+4 bits.
  - If the sum exceeds 2^OUT_W-1, set `ovf` (sticky) and clamp `acc` to all-ones. Later digits keep it clamped.
- **Invalid digit**
  - A nibble greater than 9 sets `bad_digit` (sticky).
  - The final `bin_out` is forced to 0 when `bad_digit`=1; `ovf` is still reported.
- **DONE**
  - `out_valid`=1 and `in_ready`=0.
  - `bin_out`, `ovf` and `bad_digit` are stable while waiting.
  - On `out_ready`=1: go to IDLE.
- `bin_out` and the flags hold their last values after leaving DONE. They are meaningful only while `out_valid`=1.
- Input words presented while `in_ready`=0 are ignored, not queued.

## Timing
- **Reset values:** state=IDLE, `out_valid`=0, `bin_out`=0, `ovf`=0, `bad_digit`=0. `in_ready`=0 while `reset` is high, and 1 in the first cycle after release.
- **Latency:** with acceptance at edge E0, `out_valid` is high in the cycle after edge E0+NUM_DIGITS (3 cycles for the default).
- **Throughput:** at most one word per NUM_DIGITS+2 cycles.
  - A result taken at edge Ed returns the block to IDLE, so `in_ready`=1 after Ed.
  - There is no same-cycle out/in overlap.
- **Backpressure:** `out_valid` stays high for as long as `out_ready`=0; there is no timeout.
- **Reset mid-conversion:** `reset` in CONV or DONE aborts the conversion. The partial result is discarded and `out_valid` is never asserted for the aborted word.
- `in_valid` and `out_ready` are sampled only at rising edges. No output depends combinationally on `in_valid`, `out_ready` or `bcd_in`.
- `in_ready` and `out_valid` are decoded from the state register only.

## Structure
- **Package `bcd_pkg`:**
  - `state_t` enum {IDLE, CONV, DONE}.
  - `DIGIT_W`=4.
  - `MAX_DIGIT`=9.
  - `DEF_NUM_DIGITS`=3.
  - `DEF_OUT_W`=8.
- **Sub-module `bcd_mac10`:** combinational multiply-by-10-and-add with saturation.
  - Inputs: `acc` [OUT_W-1:0] and `digit` [3:0].
  - Outputs: `acc_next` [OUT_W-1:0], `sat` and `bad`.
  - Instantiated once by the top-level FSM/datapath.
- The top level holds the FSM, digit shift register, counter of $clog2(NUM_DIGITS+1) bits, accumulator and sticky flags.

## Test plan
- **Basic conversion:** reset for 2 cycles, then `bcd_in`=0x123 with `in_valid`=1 and `out_ready`=1 → `out_valid` 3 cycles after acceptance, `bin_out`=123 (0x7B), `ovf`=0, `bad_digit`=0.
- **Overflow boundary:** 0x255 → 255 with `ovf`=0; 0x256 → 255 with `ovf`=1; 0x999 → 255 with `ovf`=1; 0x000 → 0 with both flags clear.
- **Invalid digit:** 0x1A5 → `bad_digit`=1, `bin_out`=0. 0x3F9 → `bad_digit`=1, `ovf`=1, `bin_out`=0.
- **Backpressure:** convert 0x042, hold `out_ready`=0 for 5 cycles → `out_valid`=1 and `bin_out`=42 throughout, `in_ready`=0, and a word 0x077 presented meanwhile is ignored. Then pulse `out_ready` → `in_ready`=1 on the next cycle and 0x077 converts to 77.
- **Reset mid-conversion:** accept 0x200, assert `reset` after 1 CONV cycle → `out_valid` stays 0 and all outputs are at reset values. After release, 0x010 converts to 10 with the flags clear.
- **Back-to-back:** stream 0x001, 0x128, 0x250 with `in_valid` held high and `out_ready`=1 → results 1, 128, 250 in order, each accepted 5 cycles apart.
